// File: rtl/pin_entry_terminal.sv
// PIN entry terminal: collects four BCD digits, submits them to a gate controller
// and tracks its response. Optional inactivity timer is enabled by ENTRY_TIMEOUT_EN.
module pin_entry_terminal #(
  parameter int RESP_WINDOW   = 8,
  parameter int ENTRY_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  input  logic        open_gate,
  input  logic        close_gate,
  input  logic        blocked_gate,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        status_ok,
  output logic        status_fail,
  output logic        status_locked,
  output logic        entry_timeout
);

  typedef enum logic [2:0] {COLLECT, SEND, WAIT_RESP, ACCEPTED, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [15:0] code_nxt;
  logic [2:0]  count_nxt;
  logic [7:0]  resp_cnt, resp_cnt_nxt;
  logic        fail_nxt;

`ifdef ENTRY_TIMEOUT_EN
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic        tmo_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    count_nxt    = digit_count;
    resp_cnt_nxt = '0;
    fail_nxt     = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    idle_cnt_nxt = '0;
    tmo_nxt      = 1'b0;
`endif
    case (state)
      COLLECT: begin
        if (key_clear) begin
          code_nxt  = '0;
          count_nxt = '0;
        end else if (key_valid) begin
          if (key_digit <= 4'd9 && digit_count < 3'd4) begin
            code_nxt  = {code[11:0], key_digit};
            count_nxt = digit_count + 3'd1;
          end
        end else if (key_enter) begin
          if (digit_count == 3'd4) state_nxt = SEND;
        end
`ifdef ENTRY_TIMEOUT_EN
        // Only cycles with no key strobe at all advance the idle count.
        else if (digit_count != 3'd0) begin
          if (idle_cnt == 16'(ENTRY_TIMEOUT - 1)) begin
            code_nxt  = '0;
            count_nxt = '0;
            tmo_nxt   = 1'b1;
          end else begin
            idle_cnt_nxt = idle_cnt + 16'd1;
          end
        end
`endif
      end
      SEND: state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        if (blocked_gate) begin
          state_nxt = LOCKED;
        end else if (open_gate) begin
          state_nxt = ACCEPTED;
        end else if (resp_cnt == 8'(RESP_WINDOW - 1)) begin
          state_nxt = COLLECT;
          fail_nxt  = 1'b1;
          code_nxt  = '0;
          count_nxt = '0;
        end else begin
          resp_cnt_nxt = resp_cnt + 8'd1;
        end
      end
      ACCEPTED: begin
        if (blocked_gate) begin
          state_nxt = LOCKED;
        end else if (close_gate) begin
          state_nxt = COLLECT;
          code_nxt  = '0;
          count_nxt = '0;
        end
      end
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = COLLECT;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      code          <= '0;
      digit_count   <= '0;
      resp_cnt      <= '0;
      code_ack      <= 1'b0;
      status_ok     <= 1'b0;
      status_fail   <= 1'b0;
      status_locked <= 1'b0;
    end else begin
      state         <= state_nxt;
      code          <= code_nxt;
      digit_count   <= count_nxt;
      resp_cnt      <= resp_cnt_nxt;
      code_ack      <= (state_nxt == SEND);
      status_ok     <= (state_nxt == ACCEPTED);
      status_fail   <= fail_nxt;
      status_locked <= (state_nxt == LOCKED);
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt      <= '0;
      entry_timeout <= 1'b0;
    end else begin
      idle_cnt      <= idle_cnt_nxt;
      entry_timeout <= tmo_nxt;
    end
  end
`else
  assign entry_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pin_entry_terminal.sv
// Bench for pin_entry_terminal: directed scenarios plus random key/response traffic,
// checked every cycle against a digit-queue reference model.
module tb_pin_entry_terminal;
  localparam int RW = 8;
  localparam int ET = 20;
`ifdef ENTRY_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0, key_clear = 1'b0, key_enter = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        open_gate = 1'b0, close_gate = 1'b0, blocked_gate = 1'b0;
  logic [15:0] code;
  logic        code_ack, status_ok, status_fail, status_locked, entry_timeout;
  logic [2:0]  digit_count;

  pin_entry_terminal #(.RESP_WINDOW(RW), .ENTRY_TIMEOUT(ET)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .key_enter(key_enter), .open_gate(open_gate),
    .close_gate(close_gate), .blocked_gate(blocked_gate), .code(code),
    .code_ack(code_ack), .digit_count(digit_count), .status_ok(status_ok),
    .status_fail(status_fail), .status_locked(status_locked),
    .entry_timeout(entry_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: held digits plus session phase flags.
  logic [3:0] digits[$];
  bit sending, waiting, accepted, locked;
  int wait_cycles, idle;
  bit e_ack, e_fail, e_tmo;

  function automatic logic [15:0] mcode();
    logic [15:0] c = 16'h0;
    foreach (digits[i]) c = {c[11:0], digits[i]};
    return c;
  endfunction

  task automatic model_step(input bit r, kv, input logic [3:0] kd, input bit kc, ke, og, cg, bg);
    e_ack = 0; e_fail = 0; e_tmo = 0;
    if (r) begin
      digits.delete(); sending = 0; waiting = 0; accepted = 0; locked = 0;
      wait_cycles = 0; idle = 0;
    end else if (locked) begin
    end else if (accepted) begin
      if (bg) begin accepted = 0; locked = 1; end
      else if (cg) begin accepted = 0; digits.delete(); end
    end else if (waiting) begin
      if (bg) begin waiting = 0; locked = 1; end
      else if (og) begin waiting = 0; accepted = 1; end
      else begin
        wait_cycles++;
        if (wait_cycles == RW) begin waiting = 0; e_fail = 1; digits.delete(); end
      end
    end else if (sending) begin
      sending = 0; waiting = 1; wait_cycles = 0;
    end else begin
      if (kc) begin digits.delete(); idle = 0; end
      else if (kv) begin
        if (kd <= 9 && digits.size() < 4) digits.push_back(kd);
        idle = 0;
      end else if (ke) begin
        if (digits.size() == 4) begin sending = 1; e_ack = 1; end
        idle = 0;
      end else if (TMO_EN && digits.size() > 0) begin
        idle++;
        if (idle == ET) begin digits.delete(); e_tmo = 1; idle = 0; end
      end else idle = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("code",   code, mcode());
    chk("count",  16'(digit_count), 16'(digits.size()));
    chk("ack",    16'(code_ack), 16'(e_ack));
    chk("ok",     16'(status_ok), 16'(accepted));
    chk("fail",   16'(status_fail), 16'(e_fail));
    chk("locked", 16'(status_locked), 16'(locked));
    chk("tmo",    16'(entry_timeout), 16'(e_tmo));
  endtask

  task automatic cyc(input bit r, kv, input logic [3:0] kd, input bit kc, ke, og, cg, bg);
    @(negedge clk);
    rst = r; key_valid = kv; key_digit = kd; key_clear = kc; key_enter = ke;
    open_gate = og; close_gate = cg; blocked_gate = bg;
    @(posedge clk);
    model_step(r, kv, kd, kc, ke, og, cg, bg);
    #1 check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic key(input logic [3:0] d); cyc(0, 1, d, 0, 0, 0, 0, 0); endtask
  task automatic enter(); cyc(0, 0, 4'd0, 0, 1, 0, 0, 0); endtask
  task automatic reset(); cyc(1, 0, 4'd0, 0, 0, 0, 0, 0); endtask

  initial begin
    int n;
    // Reset state
    reset(); reset();
    chk("rst_code", code, 16'h0000);
    chk("rst_cnt", 16'(digit_count), 16'd0);

    // Accepted session: 2468, open after a few cycles, then close
    key(4'd2); key(4'd4); key(4'd6); key(4'd8);
    enter();
    chk("s1_code", code, 16'h2468);
    chk("s1_ack", 16'(code_ack), 16'd1);
    idle_n(1);
    chk("s1_ack_gone", 16'(code_ack), 16'd0);
    idle_n(1);
    cyc(0, 0, 4'd0, 0, 0, 1, 0, 0);
    chk("s1_ok", 16'(status_ok), 16'd1);
    idle_n(2);
    cyc(0, 0, 4'd0, 0, 0, 0, 1, 0);
    chk("s1_closed_cnt", 16'(digit_count), 16'd0);
    chk("s1_closed_ok", 16'(status_ok), 16'd0);

    // No response: fail pulse RW cycles after WAIT_RESP entry
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    enter();
    n = 0;
    do begin idle_n(1); n++; end while (!status_fail && n < 50);
    chk("s2_fail_lat", 16'(n - 1), 16'(RW));
    chk("s2_code", code, 16'h0000);
    idle_n(1);

    // Invalid digit and short enter ignored; clear beats a simultaneous key
    key(4'd2); key(4'd4); key(4'hA);
    enter();
    chk("s3_cnt", 16'(digit_count), 16'd2);
    chk("s3_no_ack", 16'(code_ack), 16'd0);
    cyc(0, 1, 4'd5, 1, 0, 0, 0, 0);
    chk("s3_clear", 16'(digit_count), 16'd0);

    // Fifth digit ignored, lockout, then reset
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd7);
    chk("s4_code", code, 16'h9999);
    enter(); idle_n(2);
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 1);
    chk("s4_locked", 16'(status_locked), 16'd1);
    key(4'd1); cyc(0, 0, 4'd0, 1, 1, 1, 1, 0);
    chk("s4_still_locked", 16'(status_locked), 16'd1);
    reset();
    chk("s4_rst_locked", 16'(status_locked), 16'd0);
    chk("s4_rst_code", code, 16'h0000);

    // Inactivity on a partial entry
    key(4'd3);
    idle_n(ET);
    chk("s5_tmo", 16'(entry_timeout), 16'(TMO_EN));
    chk("s5_cnt", 16'(digit_count), TMO_EN ? 16'd0 : 16'd1);
    idle_n(3);
    reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 149) == 0, ($urandom % 100) < 30, 4'($urandom_range(0, 11)),
          ($urandom % 100) < 3, ($urandom % 100) < 20, ($urandom % 100) < 10,
          ($urandom % 100) < 10, ($urandom % 100) < 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pin_entry_terminal.md
PIN_ENTRY_TERMINAL -- requirements
Module: pin_entry_terminal

Interface
REQ-001 Parameter RESP_WINDOW, default 8: cycles to wait for a controller response after code_ack (range 2..255).
REQ-002 Parameter ENTRY_TIMEOUT, default 1000: idle cycles before a partial entry is discarded (range 1..65535; used only with ENTRY_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  one-cycle strobe: key_digit holds a keypress.
REQ-006 key_digit  input  4  BCD digit 0..9.
REQ-007 key_clear  input  1  one-cycle strobe: discard the digits entered so far.
REQ-008 key_enter  input  1  one-cycle strobe: submit the entry.
REQ-009 open_gate  input  1  controller response: PIN accepted, gate open.
REQ-010 close_gate  input  1  controller response: gate closing, session over.
REQ-011 blocked_gate  input  1  controller response: lockout.
REQ-012 code  output  16  assembled PIN, 4 BCD nibbles, first digit in [15:12].
REQ-013 code_ack  output  1  one-cycle strobe: code is valid.
REQ-014 digit_count  output  3  number of digits held, 0..4.
REQ-015 status_ok  output  1  high in ACCEPTED.
REQ-016 status_fail  output  1  one-cycle pulse on rejection.
REQ-017 status_locked  output  1  high in LOCKED.
REQ-018 entry_timeout  output  1  one-cycle pulse when a partial entry is discarded for inactivity.

Function
REQ-019 States SHALL be COLLECT, SEND, WAIT_RESP, ACCEPTED and LOCKED; all outputs SHALL be registered.
REQ-020 In COLLECT, key_valid with key_digit<=9 and digit_count<4 SHALL set code<={code[11:0],key_digit} and increment digit_count the next cycle.
REQ-021 key_digit>9, or key_valid with digit_count==4, SHALL be ignored with no state change.
REQ-022 In COLLECT, key_clear SHALL zero code and digit_count; key_clear SHALL have priority over key_valid and key_enter in the same cycle.
REQ-023 In COLLECT, key_enter with digit_count==4 and key_valid low SHALL move to SEND; any other key_enter SHALL be ignored.
REQ-024 SEND SHALL last exactly one cycle with code_ack=1, then move to WAIT_RESP; code_ack SHALL be 0 in every other state.
REQ-025 code SHALL hold stable from SEND until the FSM leaves WAIT_RESP; key inputs SHALL be ignored outside COLLECT.
REQ-026 WAIT_RESP response priority SHALL be:
  - blocked_gate -> LOCKED;
  - else open_gate -> ACCEPTED;
  - else after RESP_WINDOW cycles -> COLLECT, with status_fail pulsed for one cycle and code/digit_count zeroed.
REQ-027 ACCEPTED SHALL hold status_ok=1 until close_gate, then go to COLLECT with the entry zeroed; blocked_gate in ACCEPTED SHALL move to LOCKED.
REQ-028 LOCKED SHALL hold status_locked=1 and ignore all inputs until rst.
REQ-029 The response counter SHALL restart from 0 on each entry to WAIT_RESP.

Reset
REQ-030 When rst is high at posedge clk:
  - state SHALL become COLLECT;
  - code=16'h0000, digit_count=0, all strobes/status=0, all counters=0;
  - this SHALL apply from any state, including mid-entry and WAIT_RESP.

Configuration
REQ-031 With macro ENTRY_TIMEOUT_EN defined:
  - in COLLECT with digit_count>0, ENTRY_TIMEOUT consecutive cycles with no key_valid/key_clear/key_enter SHALL zero the entry and pulse entry_timeout for one cycle;
  - any key strobe SHALL restart the count.
REQ-032 Without ENTRY_TIMEOUT_EN, entry_timeout SHALL be tied 0, no timer SHALL be instantiated, and a partial entry SHALL persist indefinitely.

Verification
REQ-033 Keys 2,4,6,8 then enter -> code=16'h2468, code_ack high exactly 1 cycle; open_gate at +3 -> status_ok=1; close_gate -> COLLECT, digit_count=0.
REQ-034 Keys 1,2,3,4, enter, no response -> status_fail pulses exactly RESP_WINDOW(8) cycles after WAIT_RESP entry; code=0.
REQ-035 Keys 2,4, key_digit=4'hA, enter -> digit_count=2, no code_ack; then key_clear together with key_valid(5) -> digit_count=0.
REQ-036 Keys 9,9,9,9,7 -> code=16'h9999; blocked_gate during WAIT_RESP -> status_locked=1, later key input ignored; rst -> all outputs 0.
REQ-037 With ENTRY_TIMEOUT_EN and ENTRY_TIMEOUT=20: key 3, then 20 idle cycles -> entry_timeout pulse, digit_count=0; without the macro -> digit_count stays 1.
